// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Constants shared by the MIPS inter-stage pipeline registers.
//   WIDTH_DEFAULT : default payload width (instruction / PC / operand word)
//   DEPTH_MIN/MAX : legal range for the number of register stages
//   FLUSH_ALL     : flush mask that kills every stage of a maximal-depth chain
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_MIN     = 1;
    localparam int DEPTH_MAX     = 8;

    localparam logic [DEPTH_MAX-1:0] FLUSH_ALL = '1;

endpackage : mips_pipe_pkg

// File: rtl/pipe_stage_cell.sv
// -----------------------------------------------------------------------------
// pipe_stage_cell
// One stage of the elastic pipeline: a valid bit plus a payload register.
// Ports:
//   clk, rst_n  : pipeline clock, asynchronous active-low reset (valid only)
//   prev_valid  : valid of the older-side source (previous stage or input)
//   prev_data   : payload of the source
//   next_ready  : ready of the following stage (or out_ready for the last)
//   flush       : kill this stage's valid at the coming edge
//   ready       : this stage can load at the coming edge
//   valid       : registered valid
//   valid_nxt   : valid as it will be after the coming edge (post-flush)
//   data        : registered payload
// -----------------------------------------------------------------------------
module pipe_stage_cell
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    input  logic             flush,
    output logic             ready,
    output logic             valid,
    output logic             valid_nxt,
    output logic [WIDTH-1:0] data
);

    // Ready is derived from the pre-flush valid, so a flush never disturbs
    // the handshake seen by upstream; a beat loaded while flushed is dropped.
    always_comb begin
        ready     = !valid || next_ready;
        valid_nxt = ready ? prev_valid : valid;
        if (flush) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Payload is not reset; it is only meaningful while valid is set.
    always_ff @(posedge clk) begin
        if (ready && prev_valid) begin
            data <= prev_data;
        end
    end

endmodule : pipe_stage_cell

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
// DEPTH-stage, WIDTH-bit elastic pipeline register chain with valid/ready
// handshake, bubble collapse and per-stage flush. Replaces the fixed
// inter-stage latches of the MIPS datapath.
// Ports:
//   clk, rst_n           : pipeline clock, asynchronous active-low reset
//   in_valid/in_data     : upstream beat;  in_ready : chain accepts it
//   out_valid/out_data   : oldest beat;    out_ready : downstream takes it
//   flush_mask[DEPTH]    : bit i kills stage i this cycle (0 = youngest)
//   occupancy[CNT_W]     : registered count of valid entries
// Build option:
//   ELASTIC_PIPE_SKID_EN : adds a one-entry skid buffer at the input so that
//                          in_ready comes straight from a flop; capacity is
//                          then DEPTH+1. Undefined: in_ready is combinational
//                          from out_ready through the ready chain.
// -----------------------------------------------------------------------------
module elastic_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [CNT_W-1:0] occupancy
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH out of range");
    end
    if ((1 << CNT_W) <= DEPTH + 1) begin : g_bad_cnt_w
        $error("elastic_pipe_reg: CNT_W too narrow for DEPTH");
    end

    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [WIDTH-1:0] data [DEPTH];
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [CNT_W-1:0] skid_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign ready[DEPTH] = out_ready;

`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic [WIDTH-1:0] skid_data;
    logic             skid_park;

    // A beat parks only when it is accepted while stage 0 is blocked.
    assign skid_park = !skid_valid && in_valid && !ready[0];
    assign in_ready  = !skid_valid;
    // The parked beat is older than anything on in_data, so it drains first.
    assign src_valid = skid_valid || in_valid;
    assign src_data  = skid_valid ? skid_data : in_data;

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (skid_valid && ready[0]) begin
            skid_valid_nxt = 1'b0;
        end
        if (skid_park) begin
            skid_valid_nxt = 1'b1;
        end
        if (flush_mask[0]) begin
            skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (skid_park) begin
            skid_data <= in_data;
        end
    end

    assign skid_cnt = CNT_W'(skid_valid_nxt);
`else
    assign in_ready  = ready[0];
    assign src_valid = in_valid;
    assign src_data  = in_data;
    assign skid_cnt  = '0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = src_valid;
            assign prev_data  = src_data;
        end else begin : g_body
            assign prev_valid = valid[i-1];
            assign prev_data  = data[i-1];
        end

        pipe_stage_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .next_ready (ready[i+1]),
            .flush      (flush_mask[i]),
            .ready      (ready[i]),
            .valid      (valid[i]),
            .valid_nxt  (valid_nxt[i]),
            .data       (data[i])
        );
    end

    // Occupancy is the popcount of the post-edge (post-flush) valids.
    always_comb begin
        cnt_nxt = skid_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= cnt_nxt;
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule : elastic_pipe_reg

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
// Directed bench for elastic_pipe_reg (WIDTH=32, DEPTH=3). The driver pushes
// every beat expected to leave the chain into a queue when it is accepted; a
// separate monitor pops and compares on each output transfer.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;
`ifdef ELASTIC_PIPE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [DEPTH-1:0] flush_mask;
    logic [CNT_W-1:0] occupancy;

    logic [WIDTH-1:0] exp_q[$];
    int               checks   = 0;
    int               failures = 0;

    elastic_pipe_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Inputs change on the falling edge; acceptance is sampled 2ns later,
    // well before the next rising edge that performs the transfer.
    task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                        input logic [DEPTH-1:0] fl, input logic keep);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        out_ready  = ordy;
        flush_mask = fl;
        #2;
        if (v && in_ready && keep) exp_q.push_back(d);
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush_mask = '0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0);
        chk("rst_in_ready", in_ready, 1);

        // Free flow: 1..5, out_valid rises 3 cycles after the first push.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'(i + 1), 1, 0, 1);
            chk("ff_latency", out_valid, (i >= 3) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            chk("ff_no_gap", out_valid, 1);
        end
        step(0, 0, 1, 0, 0);
        chk("ff_empty", out_valid, 0);

        // Stall and fill.
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hA1 + 32'(i), 0, 0, 1);
            chk("fill_in_ready", in_ready, 1);
        end
        step(1, 32'hA4, 0, 0, 1);
        chk("full_in_ready", in_ready, SKID);
        chk("full_occupancy", occupancy, 3);
`ifdef ELASTIC_PIPE_SKID_EN
        step(0, 0, 0, 0, 0);
        chk("skid_in_ready", in_ready, 0);
        chk("skid_occupancy", occupancy, 4);
`else
        step(1, 32'hA4, 1, 0, 1);
        chk("a4_accept", in_ready, 1);
`endif
        repeat (6) step(0, 0, 1, 0, 0);
        chk("fill_drained", occupancy, 0);

        // Bubble collapse under stall.
        step(1, 32'hB1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 32'hB2, 0, 0, 1);
        chk("bub_in_ready", in_ready, 1);
        step(0, 0, 0, 0, 0);
        chk("bub_occupancy", occupancy, 2);
        chk("bub_ready_hold", in_ready, 1);
        repeat (5) step(0, 0, 1, 0, 0);

        // Flush the two younger stages of a full chain.
        step(1, 32'hC1, 0, 0, 1);
        step(1, 32'hC2, 0, 0, 0);
        step(1, 32'hC3, 0, 0, 0);
        step(0, 0, 0, 3'b011, 0);
        chk("fl_pre_occ", occupancy, 3);
        step(0, 0, 0, 0, 0);
        chk("fl_occupancy", occupancy, 1);
        chk("fl_out_data", out_data, 32'hC1);
        repeat (4) step(0, 0, 1, 0, 0);

        // Flush of stage 0 racing a load: beat accepted but dropped.
        step(1, 32'hD1, 1, 3'b001, 0);
        chk("race_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            chk("race_no_out", out_valid, 0);
        end

        // Flush of the last stage still completes the output transfer.
        step(1, 32'hE1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 3'b100, 0);
        chk("last_fl_valid", out_valid, 1);
        step(0, 0, 1, 0, 0);
        chk("last_fl_empty", out_valid, 0);
        chk("last_fl_occ", occupancy, 0);

        // Asynchronous reset with two beats in flight.
        step(1, 32'hF1, 0, 0, 0);
        step(1, 32'hF2, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ar_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_occupancy", occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0);
        chk("ar_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk("ar_no_stale", out_valid, 0);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_elastic_pipe_reg
